// File: rtl/lane_read_training_ctrl_if.sv
// Signal bundle between the lane IOD read-training instance, the training master
// and the per-lane read-training sequencer.
interface lane_read_training_ctrl_if #(
    parameter int TAP_W = 7
);
    logic               train_start;
    logic [7:0]         rx_data;
    logic               eye_monitor_early;
    logic               eye_monitor_late;
    logic               delay_line_out_of_range;
    logic               delay_line_load;
    logic               delay_line_move;
    logic               delay_line_direction;
    logic               eye_monitor_clear_flags;
    logic               train_busy;
    logic               train_done;
    logic               train_fail;
    logic [TAP_W-1:0]   win_start;
    logic [TAP_W:0]     win_len;
    logic [TAP_W-1:0]   final_tap;

    modport master (
        output train_start, rx_data, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        input  delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
        input  train_busy, train_done, train_fail, win_start, win_len, final_tap
    );

    modport slave (
        input  train_start, rx_data, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        output delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
        output train_busy, train_done, train_fail, win_start, win_len, final_tap
    );
endinterface

// File: rtl/lane_read_training_ctrl.sv
// Per-lane read-training sequencer: sweeps the RX delay line, finds the longest passing
// window of the training pattern and parks the delay line at the window centre.
//
// state  | meaning
// IDLE   | waiting for a start request
// LOAD   | reload delay line to tap 0, clear sweep bookkeeping
// CLEAR  | clear eye-monitor flags, clear per-tap error
// SETTLE | wait for the delay line to settle
// SAMPLE | compare RX words and eye flags against the pattern
// EVAL   | update running / best window, decide end of sweep
// STEP   | move the delay line one tap up
// RELOAD | reload to tap 0, compute the centre tap
// CENTER | walk the delay line up to the centre tap
// DONE   | result valid, waiting for the next start
module lane_read_training_ctrl #(
    parameter int         MAX_TAPS   = 128,
    parameter int         TAP_W      = 7,
    parameter int         SETTLE_CYC = 8,
    parameter int         SAMPLE_CYC = 16,
    parameter logic [7:0] PATTERN    = 8'h55,
    parameter int         MIN_WINDOW = 4
) (
    input  logic                      i_fab_clk,
    input  logic                      i_rx_sync_rst,
    lane_read_training_ctrl_if.slave  io_lane
);

    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
        S_EVAL, S_STEP, S_RELOAD, S_CENTER, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [TAP_W-1:0]   r_tap, w_tap_nxt;
    logic [TAP_W:0]     r_run_len, w_run_len_nxt;
    logic [TAP_W-1:0]   r_run_start, w_run_start_nxt;
    logic [TAP_W:0]     r_best_len, w_best_len_nxt;
    logic [TAP_W-1:0]   r_best_start, w_best_start_nxt;
    logic               r_err, w_err_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [TAP_W-1:0]   r_step_cnt, w_step_cnt_nxt;
    logic [TAP_W-1:0]   r_target, w_target_nxt;
    logic               r_phase, w_phase_nxt;
    logic               r_load, r_move, r_dir, r_clr, r_busy, r_done, r_fail, w_fail_nxt;
    logic [TAP_W-1:0]   r_win_start, w_win_start_nxt;
    logic [TAP_W:0]     r_win_len, w_win_len_nxt;
    logic [TAP_W-1:0]   r_final_tap, w_final_tap_nxt;
    logic [TAP_W:0]     w_centre;
    logic               w_move_nxt;

    // Centre of the best window, rounded down; cannot exceed the last tap.
    assign w_centre = {1'b0, r_best_start} + ((r_best_len - (TAP_W+1)'(1)) >> 1);

    always_comb begin
        w_state_nxt      = r_state;
        w_tap_nxt        = r_tap;
        w_run_len_nxt    = r_run_len;
        w_run_start_nxt  = r_run_start;
        w_best_len_nxt   = r_best_len;
        w_best_start_nxt = r_best_start;
        w_err_nxt        = r_err;
        w_cnt_nxt        = r_cnt;
        w_step_cnt_nxt   = r_step_cnt;
        w_target_nxt     = r_target;
        w_phase_nxt      = r_phase;
        w_fail_nxt       = r_fail;
        w_win_start_nxt  = r_win_start;
        w_win_len_nxt    = r_win_len;
        w_final_tap_nxt  = r_final_tap;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (io_lane.train_start) begin
                    w_state_nxt      = S_LOAD;
                    w_fail_nxt       = 1'b0;
                    w_win_start_nxt  = '0;
                    w_win_len_nxt    = '0;
                    w_final_tap_nxt  = '0;
                    w_tap_nxt        = '0;
                    w_run_len_nxt    = '0;
                    w_best_len_nxt   = '0;
                    w_best_start_nxt = '0;
                end
            end
            S_LOAD: w_state_nxt = S_CLEAR;
            S_CLEAR: begin
                w_err_nxt   = 1'b0;
                w_cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = CNT_W'(SAMPLE_CYC - 1);
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                w_err_nxt = r_err | (io_lane.rx_data != PATTERN)
                          | io_lane.eye_monitor_early | io_lane.eye_monitor_late;
                if (r_cnt == '0) w_state_nxt = S_EVAL;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            S_EVAL: begin
                if (!r_err) begin
                    if (r_run_len == '0) w_run_start_nxt = r_tap;
                    w_run_len_nxt = r_run_len + (TAP_W+1)'(1);
                    // Strictly greater keeps the earliest window on a tie.
                    if (w_run_len_nxt > r_best_len) begin
                        w_best_len_nxt   = w_run_len_nxt;
                        w_best_start_nxt = w_run_start_nxt;
                    end
                end else begin
                    w_run_len_nxt = '0;
                end
                if ((r_tap == TAP_W'(MAX_TAPS - 1)) || io_lane.delay_line_out_of_range) begin
                    w_state_nxt     = S_RELOAD;
                    w_win_start_nxt = w_best_start_nxt;
                    w_win_len_nxt   = w_best_len_nxt;
                end else begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                w_tap_nxt   = r_tap + TAP_W'(1);
                w_state_nxt = S_CLEAR;
            end
            S_RELOAD: begin
                w_step_cnt_nxt = '0;
                w_phase_nxt    = 1'b0;
                if (r_best_len < (TAP_W+1)'(MIN_WINDOW)) begin
                    w_fail_nxt      = 1'b1;
                    w_final_tap_nxt = '0;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_target_nxt    = w_centre[TAP_W-1:0];
                    w_fail_nxt      = 1'b0;
                    w_final_tap_nxt = '0;
                    w_state_nxt     = (w_centre[TAP_W-1:0] == '0) ? S_DONE : S_CENTER;
                end
            end
            S_CENTER: begin
                if (io_lane.delay_line_out_of_range) begin
                    w_fail_nxt      = 1'b1;
                    w_final_tap_nxt = r_step_cnt;
                    w_state_nxt     = S_DONE;
                end else if (!r_phase) begin
                    w_step_cnt_nxt = r_step_cnt + TAP_W'(1);
                    w_phase_nxt    = 1'b1;
                    if (w_step_cnt_nxt == r_target) begin
                        w_fail_nxt      = 1'b0;
                        w_final_tap_nxt = r_target;
                        w_state_nxt     = S_DONE;
                    end
                end else begin
                    w_phase_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_move_nxt = (w_state_nxt == S_STEP) || ((w_state_nxt == S_CENTER) && !w_phase_nxt);

    always_ff @(posedge i_fab_clk) begin
        if (i_rx_sync_rst) begin
            r_state      <= S_IDLE;
            r_tap        <= '0;
            r_run_len    <= '0;
            r_run_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_step_cnt   <= '0;
            r_target     <= '0;
            r_phase      <= 1'b0;
            r_load       <= 1'b0;
            r_move       <= 1'b0;
            r_dir        <= 1'b0;
            r_clr        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_win_start  <= '0;
            r_win_len    <= '0;
            r_final_tap  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_tap        <= w_tap_nxt;
            r_run_len    <= w_run_len_nxt;
            r_run_start  <= w_run_start_nxt;
            r_best_len   <= w_best_len_nxt;
            r_best_start <= w_best_start_nxt;
            r_err        <= w_err_nxt;
            r_cnt        <= w_cnt_nxt;
            r_step_cnt   <= w_step_cnt_nxt;
            r_target     <= w_target_nxt;
            r_phase      <= w_phase_nxt;
            r_load       <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RELOAD);
            r_move       <= w_move_nxt;
            r_dir        <= w_move_nxt;
            r_clr        <= (w_state_nxt == S_CLEAR);
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done       <= (w_state_nxt == S_DONE);
            r_fail       <= w_fail_nxt;
            r_win_start  <= w_win_start_nxt;
            r_win_len    <= w_win_len_nxt;
            r_final_tap  <= w_final_tap_nxt;
        end
    end

    assign io_lane.delay_line_load         = r_load;
    assign io_lane.delay_line_move         = r_move;
    assign io_lane.delay_line_direction    = r_dir;
    assign io_lane.eye_monitor_clear_flags = r_clr;
    assign io_lane.train_busy              = r_busy;
    assign io_lane.train_done              = r_done;
    assign io_lane.train_fail              = r_fail;
    assign io_lane.win_start               = r_win_start;
    assign io_lane.win_len                 = r_win_len;
    assign io_lane.final_tap               = r_final_tap;

endmodule

// File: tb/tb_lane_read_training_ctrl.sv
// Bench for lane_read_training_ctrl: models the IOD delay line and lane data, and checks
// each training run against a window search computed from the pass/fail map of the taps.
module tb_lane_read_training_ctrl;

    localparam int MAX_TAPS   = 128;
    localparam int TAP_W      = 7;
    localparam int SETTLE_CYC = 8;
    localparam int SAMPLE_CYC = 16;
    localparam int MIN_WINDOW = 4;
    localparam int TAP_PERIOD = SETTLE_CYC + SAMPLE_CYC + 3;
    localparam int NO_TAP     = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lane_read_training_ctrl_if #(.TAP_W(TAP_W)) lane ();

    lane_read_training_ctrl #(
        .MAX_TAPS   (MAX_TAPS),
        .TAP_W      (TAP_W),
        .SETTLE_CYC (SETTLE_CYC),
        .SAMPLE_CYC (SAMPLE_CYC),
        .PATTERN    (8'h55),
        .MIN_WINDOW (MIN_WINDOW)
    ) dut (
        .i_fab_clk     (clk),
        .i_rx_sync_rst (rst),
        .io_lane       (lane)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    bit good [MAX_TAPS];
    int oor_tap, late_tap;
    int iod_tap, late_cd, cyc;
    int n_moves, n_loads, moves_since_load, last_move_cyc, period, n_overlap, n_dirbad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One fabric cycle: observe DUT pulses at the negedge, advance the IOD model, drive lane inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (int'(lane.delay_line_load) + int'(lane.delay_line_move)
            + int'(lane.eye_monitor_clear_flags) > 1) n_overlap++;
        if (lane.delay_line_move && !lane.delay_line_direction) n_dirbad++;
        lane.eye_monitor_late = 1'b0;
        if (late_cd > 0) begin
            late_cd--;
            if (late_cd == 0) lane.eye_monitor_late = 1'b1;
        end
        if (lane.delay_line_load) begin
            iod_tap          = 0;
            n_loads++;
            moves_since_load = 0;
            last_move_cyc    = -1;
        end
        if (lane.delay_line_move) begin
            iod_tap++;
            n_moves++;
            moves_since_load++;
            if (n_loads == 1) begin
                if (last_move_cyc >= 0) period = cyc - last_move_cyc;
                last_move_cyc = cyc;
            end
            if (iod_tap == late_tap && n_loads == 1) late_cd = 12;
        end
        lane.delay_line_out_of_range = (iod_tap >= oor_tap);
        if (iod_tap < MAX_TAPS && good[iod_tap]) lane.rx_data = 8'h55;
        else                                     lane.rx_data = 8'h55 ^ 8'($urandom_range(1, 255));
    endtask

    task automatic clear_map();
        for (int t = 0; t < MAX_TAPS; t++) good[t] = 1'b0;
        oor_tap  = NO_TAP;
        late_tap = -1;
    endtask

    task automatic set_window(input int s, input int l);
        for (int t = s; t < s + l && t < MAX_TAPS; t++) good[t] = 1'b1;
    endtask

    // Reference: list all maximal passing segments over the swept taps, keep the first longest.
    task automatic reference(output int e_start, output int e_len, output int e_final,
                             output int e_fail, output int e_sweep);
        int seg_s[$];
        int seg_l[$];
        int t;
        int s;
        e_sweep = (oor_tap < MAX_TAPS - 1) ? oor_tap : MAX_TAPS - 1;
        t = 0;
        while (t <= e_sweep) begin
            if (good[t] && t != late_tap) begin
                s = t;
                while (t <= e_sweep && good[t] && t != late_tap) t++;
                seg_s.push_back(s);
                seg_l.push_back(t - s);
            end else begin
                t++;
            end
        end
        e_start = 0;
        e_len   = 0;
        foreach (seg_l[i]) if (seg_l[i] > e_len) begin
            e_len   = seg_l[i];
            e_start = seg_s[i];
        end
        e_fail  = (e_len < MIN_WINDOW) ? 1 : 0;
        e_final = e_fail ? 0 : e_start + (e_len - 1) / 2;
    endtask

    task automatic run_training(input string tag, input bit inject_start);
        int e_start, e_len, e_final, e_fail, e_sweep;
        reference(e_start, e_len, e_final, e_fail, e_sweep);
        n_moves = 0; n_loads = 0; moves_since_load = 0; last_move_cyc = -1;
        period = 0; n_overlap = 0; n_dirbad = 0; late_cd = 0;
        lane.train_start = 1'b1;
        tick();
        lane.train_start = 1'b0;
        for (int i = 0; i < 6000 && !lane.train_done; i++) begin
            tick();
            lane.train_start = (inject_start && i == 500);
        end
        lane.train_start = 1'b0;
        check({tag, " done"},       32'(lane.train_done), 1);
        check({tag, " busy"},       32'(lane.train_busy), 0);
        check({tag, " fail"},       32'(lane.train_fail), e_fail);
        check({tag, " win_start"},  32'(lane.win_start), e_start);
        check({tag, " win_len"},    32'(lane.win_len), e_len);
        check({tag, " final_tap"},  32'(lane.final_tap), e_final);
        check({tag, " loads"},      n_loads, 2);
        check({tag, " centre moves"}, moves_since_load, e_final);
        check({tag, " total moves"},  n_moves, e_sweep + e_final);
        check({tag, " pulse overlap"}, n_overlap, 0);
        check({tag, " direction"},  n_dirbad, 0);
        if (e_sweep >= 2) check({tag, " tap period"}, period, TAP_PERIOD);
        tick();
        tick();
        check({tag, " done held"},  32'(lane.train_done), 1);
        check({tag, " final held"}, 32'(lane.final_tap), e_final);
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({lane.delay_line_load, lane.delay_line_move, lane.delay_line_direction,
                    lane.eye_monitor_clear_flags, lane.train_busy, lane.train_done,
                    lane.train_fail, lane.win_start, lane.win_len, lane.final_tap});
    endfunction

    initial begin
        int s1, l1, s2, l2;
        lane.train_start             = 1'b0;
        lane.rx_data                 = 8'h00;
        lane.eye_monitor_early       = 1'b0;
        lane.eye_monitor_late        = 1'b0;
        lane.delay_line_out_of_range = 1'b0;
        iod_tap = 0; late_cd = 0; cyc = 0;
        clear_map();
        rst = 1'b1;
        repeat (3) tick();
        check("reset outputs", all_outputs(), 0);
        rst = 1'b0;
        tick();
        check("idle outputs", all_outputs(), 0);

        clear_map(); set_window(20, 20);
        run_training("window 20..39", 1'b0);

        clear_map(); set_window(10, 6); set_window(50, 10);
        run_training("longer second window", 1'b0);

        clear_map(); set_window(10, 8); set_window(40, 8);
        run_training("tie first wins", 1'b0);

        clear_map(); set_window(5, 3);
        run_training("short window", 1'b0);

        clear_map(); set_window(50, MAX_TAPS - 50); oor_tap = 60; late_tap = 55;
        run_training("out of range with late flag", 1'b0);

        // Reset in the middle of sampling tap 30, then retrain with a stray start while busy.
        clear_map(); set_window(20, 20);
        lane.train_start = 1'b1;
        tick();
        lane.train_start = 1'b0;
        for (int i = 0; i < 2000 && iod_tap != 30; i++) tick();
        check("reached tap 30", iod_tap, 30);
        repeat (14) tick();
        check("busy before reset", 32'(lane.train_busy), 1);
        rst = 1'b1;
        tick();
        check("mid-run reset outputs", all_outputs(), 0);
        check("delay line untouched", iod_tap, 30);
        rst = 1'b0;
        repeat (5) tick();
        check("idle after reset", all_outputs(), 0);
        run_training("restart after reset", 1'b1);

        for (int r = 0; r < 3; r++) begin
            clear_map();
            s1 = $urandom_range(0, 50);
            l1 = $urandom_range(1, 20);
            s2 = $urandom_range(s1 + l1 + 1, 110);
            l2 = $urandom_range(1, 20);
            set_window(s1, l1);
            set_window(s2, l2);
            if ($urandom_range(0, 1) == 1) oor_tap = $urandom_range(s2, MAX_TAPS - 1);
            run_training($sformatf("random %0d", r), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
